// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants for the two-requester register-file write arbiter.
package rf_write_arbiter_pkg;

    localparam int RSIZE_DEF = 4;
    localparam int DSIZE_DEF = 16;

    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;

    localparam int CONF_W = 8;
    localparam logic [CONF_W-1:0] CONF_MAX = {CONF_W{1'b1}};

    function automatic logic [CONF_W-1:0] sat_inc(input logic [CONF_W-1:0] val);
        return (val == CONF_MAX) ? val : val + 1'b1;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to
// the requester that was not granted last.
module rr_arb2
    import rf_write_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt[REQ_ALU] = 1'b1;
            2'b10:   gnt[REQ_MEM] = 1'b1;
            2'b11: begin
                if (last) gnt[REQ_ALU] = 1'b1;
                else      gnt[REQ_MEM] = 1'b1;
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write arbiter: ALU and memory writeback share one write port.
// Optional macro RF_ZERO_REG_EN suppresses writes to register 0.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int RSIZE = RSIZE_DEF,
    parameter int DSIZE = DSIZE_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Req0_Valid,
    input  logic [RSIZE-1:0]  Req0_Addr,
    input  logic [DSIZE-1:0]  Req0_Data,
    output logic              Req0_Ready,
    input  logic              Req1_Valid,
    input  logic [RSIZE-1:0]  Req1_Addr,
    input  logic [DSIZE-1:0]  Req1_Data,
    output logic              Req1_Ready,
    input  logic [RSIZE-1:0]  RAddr1,
    input  logic [RSIZE-1:0]  RAddr2,
    output logic              Wen,
    output logic [RSIZE-1:0]  WAddr,
    output logic [DSIZE-1:0]  WData,
    output logic              Hazard1,
    output logic              Hazard2,
    output logic [CONF_W-1:0] Conflicts
);

    logic             last;
    logic [1:0]       gnt;
    logic             accept;
    logic             commit;
    logic             both_valid;
    logic [RSIZE-1:0] sel_addr;
    logic [DSIZE-1:0] sel_data;

    rr_arb2 u_arb (
        .req  ({Req1_Valid, Req0_Valid}),
        .last (last),
        .gnt  (gnt)
    );

    // Nothing is granted while reset is held, so no stale acceptance survives it.
    assign Req0_Ready = gnt[REQ_ALU] & Reset;
    assign Req1_Ready = gnt[REQ_MEM] & Reset;

    assign accept     = Req0_Ready | Req1_Ready;
    assign both_valid = Req0_Valid & Req1_Valid;
    assign sel_addr   = Req1_Ready ? Req1_Addr : Req0_Addr;
    assign sel_data   = Req1_Ready ? Req1_Data : Req0_Data;

`ifdef RF_ZERO_REG_EN
    assign commit = accept & (sel_addr != '0);
`else
    assign commit = accept;
`endif

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            Wen       <= 1'b0;
            WAddr     <= '0;
            WData     <= '0;
            Conflicts <= '0;
            last      <= 1'b1;
        end else begin
            Wen <= commit;
            if (commit) begin
                WAddr <= sel_addr;
                WData <= sel_data;
            end
            if (accept) begin
                last <= Req1_Ready;
            end
            if (both_valid) begin
                Conflicts <= sat_inc(Conflicts);
            end
        end
    end

    assign Hazard1 = Wen & (RAddr1 == WAddr);
    assign Hazard2 = Wen & (RAddr2 == WAddr);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter.
module tb_rf_write_arbiter;

    logic        Clock;
    logic        Reset;
    logic        Req0_Valid, Req1_Valid;
    logic [3:0]  Req0_Addr, Req1_Addr;
    logic [15:0] Req0_Data, Req1_Data;
    logic        Req0_Ready, Req1_Ready;
    logic [3:0]  RAddr1, RAddr2;
    logic        Wen;
    logic [3:0]  WAddr;
    logic [15:0] WData;
    logic        Hazard1, Hazard2;
    logic [7:0]  Conflicts;

    int errors = 0;
    int checks = 0;

    logic [15:0] rf [16];

    rf_write_arbiter #(.RSIZE(4), .DSIZE(16)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Req0_Valid (Req0_Valid),
        .Req0_Addr  (Req0_Addr),
        .Req0_Data  (Req0_Data),
        .Req0_Ready (Req0_Ready),
        .Req1_Valid (Req1_Valid),
        .Req1_Addr  (Req1_Addr),
        .Req1_Data  (Req1_Data),
        .Req1_Ready (Req1_Ready),
        .RAddr1     (RAddr1),
        .RAddr2     (RAddr2),
        .Wen        (Wen),
        .WAddr      (WAddr),
        .WData      (WData),
        .Hazard1    (Hazard1),
        .Hazard2    (Hazard2),
        .Conflicts  (Conflicts)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Register file fed by the write port, as the datapath would see it.
    always @(posedge Clock) begin
        if (Wen) rf[WAddr] <= WData;
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic clear_inputs();
        Req0_Valid = 1'b0; Req0_Addr = 4'd0; Req0_Data = 16'h0;
        Req1_Valid = 1'b0; Req1_Addr = 4'd0; Req1_Data = 16'h0;
        RAddr1 = 4'd0; RAddr2 = 4'd0;
    endtask

    task automatic do_reset();
        clear_inputs();
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        Req0_Valid = 1'b1; Req0_Addr = 4'd1; Req0_Data = 16'h1111;
        Req1_Valid = 1'b1; Req1_Addr = 4'd2; Req1_Data = 16'h2222;
        #1;
        checks++; if (Req0_Ready !== 1'b0) begin errors++; $display("FAIL rst_ready0 got=%b exp=0", Req0_Ready); end
        checks++; if (Req1_Ready !== 1'b0) begin errors++; $display("FAIL rst_ready1 got=%b exp=0", Req1_Ready); end
        tick();
        tick();
        checks++; if (Wen !== 1'b0) begin errors++; $display("FAIL rst_wen got=%b exp=0", Wen); end
        checks++; if (WAddr !== 4'd0) begin errors++; $display("FAIL rst_waddr got=%h exp=0", WAddr); end
        checks++; if (WData !== 16'h0) begin errors++; $display("FAIL rst_wdata got=%h exp=0", WData); end
        checks++; if (Conflicts !== 8'd0) begin errors++; $display("FAIL rst_conflicts got=%0d exp=0", Conflicts); end
        clear_inputs();
        Reset = 1'b1;
        #1;
    endtask

    task automatic test_single_write();
        do_reset();
        Req0_Valid = 1'b1; Req0_Addr = 4'd3; Req0_Data = 16'h0013;
        #1;
        checks++; if (Req0_Ready !== 1'b1) begin errors++; $display("FAIL single_ready0 got=%b exp=1", Req0_Ready); end
        checks++; if (Req1_Ready !== 1'b0) begin errors++; $display("FAIL single_ready1 got=%b exp=0", Req1_Ready); end
        tick();
        Req0_Valid = 1'b0;
        checks++; if (Wen !== 1'b1) begin errors++; $display("FAIL single_wen got=%b exp=1", Wen); end
        checks++; if (WAddr !== 4'd3) begin errors++; $display("FAIL single_waddr got=%h exp=3", WAddr); end
        checks++; if (WData !== 16'h0013) begin errors++; $display("FAIL single_wdata got=%h exp=0013", WData); end
        tick();
        checks++; if (Wen !== 1'b0) begin errors++; $display("FAIL single_wen_drop got=%b exp=0", Wen); end
        checks++; if (WAddr !== 4'd3) begin errors++; $display("FAIL single_waddr_hold got=%h exp=3", WAddr); end
        checks++; if (WData !== 16'h0013) begin errors++; $display("FAIL single_wdata_hold got=%h exp=0013", WData); end
        checks++; if (rf[3] !== 16'h0013) begin errors++; $display("FAIL single_rf3 got=%h exp=0013", rf[3]); end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_gnt  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [3:0]  exp_addr [4] = '{4'd1, 4'd2, 4'd8, 4'd9};
        logic [15:0] exp_data [4] = '{16'hA001, 16'hB002, 16'hA008, 16'hB009};
        do_reset();
        Req0_Valid = 1'b1; Req0_Addr = 4'd1; Req0_Data = 16'hA001;
        Req1_Valid = 1'b1; Req1_Addr = 4'd2; Req1_Data = 16'hB002;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({Req1_Ready, Req0_Ready} !== exp_gnt[i]) begin
                errors++; $display("FAIL rr_grant%0d got=%b exp=%b", i, {Req1_Ready, Req0_Ready}, exp_gnt[i]);
            end
            tick();
            if (i == 0) begin Req0_Addr = 4'd8; Req0_Data = 16'hA008; end
            if (i == 1) begin Req1_Addr = 4'd9; Req1_Data = 16'hB009; end
            if (i == 3) clear_inputs();
            checks++; if (Wen !== 1'b1) begin errors++; $display("FAIL rr_wen%0d got=%b exp=1", i, Wen); end
            checks++; if (WAddr !== exp_addr[i]) begin errors++; $display("FAIL rr_waddr%0d got=%h exp=%h", i, WAddr, exp_addr[i]); end
            checks++; if (WData !== exp_data[i]) begin errors++; $display("FAIL rr_wdata%0d got=%h exp=%h", i, WData, exp_data[i]); end
        end
        checks++; if (Conflicts !== 8'd4) begin errors++; $display("FAIL rr_conflicts got=%0d exp=4", Conflicts); end
        tick();
        checks++; if (Wen !== 1'b0) begin errors++; $display("FAIL rr_wen_end got=%b exp=0", Wen); end
    endtask

    task automatic test_same_addr();
        do_reset();
        Req0_Valid = 1'b1; Req0_Addr = 4'd5; Req0_Data = 16'h0005;
        Req1_Valid = 1'b1; Req1_Addr = 4'd5; Req1_Data = 16'h0015;
        #1;
        checks++; if ({Req1_Ready, Req0_Ready} !== 2'b01) begin errors++; $display("FAIL same_grant0 got=%b exp=01", {Req1_Ready, Req0_Ready}); end
        tick();
        Req0_Valid = 1'b0;
        checks++; if (WData !== 16'h0005) begin errors++; $display("FAIL same_wdata0 got=%h exp=0005", WData); end
        #1;
        checks++; if (Req1_Ready !== 1'b1) begin errors++; $display("FAIL same_ready1 got=%b exp=1", Req1_Ready); end
        tick();
        clear_inputs();
        checks++; if (Wen !== 1'b1 || WData !== 16'h0015) begin errors++; $display("FAIL same_commit1 got=%b/%h exp=1/0015", Wen, WData); end
        tick();
        checks++; if (rf[5] !== 16'h0015) begin errors++; $display("FAIL same_rf5 got=%h exp=0015", rf[5]); end
        checks++; if (Conflicts !== 8'd1) begin errors++; $display("FAIL same_conflicts got=%0d exp=1", Conflicts); end
    endtask

    task automatic test_hazard();
        do_reset();
        RAddr1 = 4'd7; RAddr2 = 4'd6;
        Req0_Valid = 1'b1; Req0_Addr = 4'd7; Req0_Data = 16'h0077;
        #1;
        checks++; if (Hazard1 !== 1'b0) begin errors++; $display("FAIL haz_pre1 got=%b exp=0", Hazard1); end
        tick();
        Req0_Valid = 1'b0;
        #1;
        checks++; if (Hazard1 !== 1'b1) begin errors++; $display("FAIL haz_wen1 got=%b exp=1", Hazard1); end
        checks++; if (Hazard2 !== 1'b0) begin errors++; $display("FAIL haz_wen2 got=%b exp=0", Hazard2); end
        RAddr2 = 4'd7;
        #1;
        checks++; if (Hazard2 !== 1'b1) begin errors++; $display("FAIL haz_comb2 got=%b exp=1", Hazard2); end
        tick();
        checks++; if (Hazard1 !== 1'b0) begin errors++; $display("FAIL haz_post1 got=%b exp=0", Hazard1); end
        clear_inputs();
    endtask

    task automatic test_zero_reg();
        do_reset();
        Req0_Valid = 1'b1; Req0_Addr = 4'd0; Req0_Data = 16'hFFFF;
        #1;
        checks++; if (Req0_Ready !== 1'b1) begin errors++; $display("FAIL zero_ready got=%b exp=1", Req0_Ready); end
        tick();
        clear_inputs();
`ifdef RF_ZERO_REG_EN
        checks++; if (Wen !== 1'b0) begin errors++; $display("FAIL zero_wen got=%b exp=0", Wen); end
        tick();
        checks++; if (rf[0] !== 16'h0000) begin errors++; $display("FAIL zero_rf0 got=%h exp=0000", rf[0]); end
`else
        checks++; if (Wen !== 1'b1 || WAddr !== 4'd0) begin errors++; $display("FAIL zero_wen got=%b/%h exp=1/0", Wen, WAddr); end
        tick();
        checks++; if (rf[0] !== 16'hFFFF) begin errors++; $display("FAIL zero_rf0 got=%h exp=ffff", rf[0]); end
`endif
    endtask

    task automatic test_reset_midstream();
        do_reset();
        Req0_Valid = 1'b1; Req0_Addr = 4'd1; Req0_Data = 16'h00A1;
        Req1_Valid = 1'b1; Req1_Addr = 4'd2; Req1_Data = 16'h00B2;
        tick();
        Reset = 1'b0;
        #1;
        checks++; if ({Req1_Ready, Req0_Ready} !== 2'b00) begin errors++; $display("FAIL mid_ready got=%b exp=00", {Req1_Ready, Req0_Ready}); end
        tick();
        checks++; if (Wen !== 1'b0) begin errors++; $display("FAIL mid_wen got=%b exp=0", Wen); end
        checks++; if (Conflicts !== 8'd0) begin errors++; $display("FAIL mid_conflicts got=%0d exp=0", Conflicts); end
        Reset = 1'b1;
        #1;
        checks++; if ({Req1_Ready, Req0_Ready} !== 2'b01) begin errors++; $display("FAIL mid_first_grant got=%b exp=01", {Req1_Ready, Req0_Ready}); end
        tick();
        checks++; if (Wen !== 1'b1 || WAddr !== 4'd1) begin errors++; $display("FAIL mid_commit got=%b/%h exp=1/1", Wen, WAddr); end
        clear_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        Req0_Valid = 1'b1; Req0_Addr = 4'd10; Req0_Data = 16'h1234;
        Req1_Valid = 1'b1; Req1_Addr = 4'd11; Req1_Data = 16'h5678;
        repeat (254) tick();
        checks++; if (Conflicts !== 8'd254) begin errors++; $display("FAIL sat_254 got=%0d exp=254", Conflicts); end
        repeat (6) tick();
        checks++; if (Conflicts !== 8'd255) begin errors++; $display("FAIL sat_255 got=%0d exp=255", Conflicts); end
        clear_inputs();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 16'h0;
        clear_inputs();
        Reset = 1'b0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_same_addr();
        test_hazard();
        test_zero_reg();
        test_reset_midstream();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter RSIZE, default 4, register address width (16 registers).
REQ-002 Parameter DSIZE, default 16, register data width.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset: Clock input 1, rising-edge clock; Reset input 1, synchronous active-low reset.
REQ-004 Req0_Valid input 1, requester 0 (ALU writeback) has a write pending.
REQ-005 Req0_Addr input RSIZE, requester 0 destination register.
REQ-006 Req0_Data input DSIZE, requester 0 write data.
REQ-007 Req0_Ready output 1, requester 0 write accepted this cycle.
REQ-008 Req1_Valid, Req1_Addr, Req1_Data inputs and Req1_Ready output SHALL mirror REQ-004..007 for requester 1 (memory writeback).
REQ-009 RAddr1 input RSIZE, register-file read port 1 address, for hazard compare.
REQ-010 RAddr2 input RSIZE, register-file read port 2 address, for hazard compare.
REQ-011 Wen output 1, register-file write enable, registered.
REQ-012 WAddr output RSIZE, register-file write address, registered.
REQ-013 WData output DSIZE, register-file write data, registered.
REQ-014 Hazard1 output 1, RAddr1 matches the write being committed this cycle.
REQ-015 Hazard2 output 1, RAddr2 matches the write being committed this cycle.
REQ-016 Conflicts output 8, saturating count of cycles with both requesters valid.

Function
REQ-017 A write SHALL be accepted when ReqN_Valid and ReqN_Ready are both 1 at a rising Clock edge.
REQ-018 ReqN_Ready SHALL be combinational, asserted only for the granted requester, and never asserted for both requesters in one cycle.
REQ-019 Grant rule: exactly one requester valid -> grant it; both valid -> grant the requester not granted last (round-robin); none valid -> no grant.
REQ-020 The round-robin pointer SHALL update only on an accepted write, recording the granted index.
REQ-021 Latency: an accepted write SHALL appear on Wen/WAddr/WData one cycle after acceptance, with Wen high for exactly that one cycle.
REQ-022 A cycle with no acceptance SHALL drive Wen=0 in the following cycle, while WAddr/WData hold their previous values.
REQ-023 Throughput: one write per cycle sustained; back-to-back acceptances SHALL produce back-to-back Wen pulses.
REQ-024 When both requesters are valid with the same address, the ungranted request SHALL remain pending and SHALL be committed on a later cycle, so the later commit wins in the register file.
REQ-025 HazardK SHALL equal Wen & (RAddrK == WAddr) and SHALL be purely combinational.
REQ-026 Conflicts SHALL increment on each cycle with Req0_Valid & Req1_Valid and SHALL saturate at 255.
REQ-027 Requesters SHALL hold Addr/Data stable while Valid=1 and Ready=0; the block SHALL not sample unaccepted data.

Reset
REQ-028 With Reset=0 at a rising edge: Wen=0, WAddr=0, WData=0, Conflicts=0, and the pointer SHALL favour requester 0 next.
REQ-029 While Reset=0, Req0_Ready=Req1_Ready=0 and no request SHALL be accepted.
REQ-030 An acceptance in the cycle Reset is asserted SHALL be discarded: no Wen pulse after reset.

Configuration
REQ-031 Macro RF_ZERO_REG_EN defined: requests with Addr==0 SHALL be accepted (Ready per grant) but SHALL produce Wen=0, so register 0 reads as hardwired zero.
REQ-032 RF_ZERO_REG_EN undefined: address 0 SHALL be written like any other address.

Structure
REQ-033 RSIZE/DSIZE defaults, the requester-index constants (REQ_ALU=0, REQ_MEM=1) and the conflict-counter width SHALL live in a shared package.
REQ-034 The 2-way round-robin grant logic SHALL be a sub-module rr_arb2 (inputs: req[1:0], last; output: gnt[1:0]).

Verification
REQ-035 Reset, then Req0 only (Addr=3, Data=0x0013) -> Req0_Ready=1 that cycle; next cycle Wen=1, WAddr=3, WData=0x0013; Reg_File reads 0x0013 at address 3.
REQ-036 Both valid for 4 cycles after reset, distinct addresses -> grants 0,1,0,1; Wen high for 4 consecutive cycles; Conflicts=4.
REQ-037 Both valid, same Addr=5, Req0 Data=0x0005, Req1 Data=0x0015 -> Req0 commits first, Req1 next cycle; register 5 finally reads 0x0015.
REQ-038 Commit WAddr=7, RAddr1=7, RAddr2=6 -> Hazard1=1, Hazard2=0 only in the Wen cycle.
REQ-039 RF_ZERO_REG_EN defined, Req0 Addr=0 Data=0xFFFF -> Ready=1, Wen stays 0; undefined -> Wen=1, register 0 reads 0xFFFF.
REQ-040 Reset asserted mid-stream with both valid -> Ready=0, Wen=0 next cycle, Conflicts=0; after release the first grant goes to requester 0.
